// File: rtl/axis_demod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_demod_pkg
//  Description : Shared constants and helpers for the hard-decision
//                BPSK / QPSK / 16-QAM demodulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_demod_pkg;

  // Run-time modulation selection codes; code 3 falls back to BPSK.
  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_QAM16 = 2'd2;

  // Number of hard bits produced per subcarrier for a given mode.
  function automatic logic [2:0] mode_bps(input logic [1:0] mode);
    case (mode)
      MODE_QPSK:  return 3'd2;
      MODE_QAM16: return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mqam_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : mqam_slicer
//  Description : Combinational hard-decision slicer. Produces up to four bits
//                per complex sample, LSB-aligned, first-transmitted bit in the
//                highest used position. Unused upper bits are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mqam_slicer
  import axis_demod_pkg::*;
#(
  parameter int DATA_W = 23
) (
  input  logic [DATA_W-1:0] re,
  input  logic [DATA_W-1:0] im,
  input  logic [DATA_W-1:0] thr16,
  input  logic [1:0]        mode,
  output logic [3:0]        bits,
  output logic [2:0]        bps
);

  localparam logic [DATA_W-1:0] C_ABS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] C_NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Magnitude of a two's-complement value; the most-negative code has no
  // positive twin and is clamped to the largest positive value instead.
  function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
    if (!x[DATA_W-1]) begin
      return x;
    end else if (x == C_NEG_MIN) begin
      return C_ABS_MAX;
    end else begin
      return -x;
    end
  endfunction

  logic w_sr;
  logic w_si;
  logic w_re_inner;
  logic w_im_inner;

  assign w_sr       = ~re[DATA_W-1];
  assign w_si       = ~im[DATA_W-1];
  assign w_re_inner = (sat_abs(re) < thr16);
  assign w_im_inner = (sat_abs(im) < thr16);

  // Select the decision bits for the active constellation.
  always_comb begin
    bits = 4'b0000;
    bps  = mode_bps(mode);
    case (mode)
      MODE_QPSK:  bits = {2'b00, w_sr, w_si};
      MODE_QAM16: bits = {w_sr, w_re_inner, w_si, w_im_inner};
      default:    bits = {3'b000, w_sr};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axis_mqam_demod.sv
`default_nettype none
// ============================================================================
//  Module      : axis_mqam_demod
//  Description : AXI4-Stream hard-decision demodulator. Slices one equalised
//                subcarrier per beat (BPSK/QPSK/16-QAM), packs the bits
//                MSB-first into OUT_W-bit words, marks the last word of each
//                OFDM symbol with tlast and flags tlast/length disagreement.
//                A one-word pending slot in the accumulator gives full
//                backpressure without bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_mqam_demod
  import axis_demod_pkg::*;
#(
  parameter int DATA_W = 23,
  parameter int N_SC   = 64,
  parameter int OUT_W  = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [47:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] thr16,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(OUT_W + 1);
  localparam int SYM_W = $clog2(N_SC);
  localparam logic [CNT_W-1:0] C_WORD_BITS = CNT_W'(OUT_W);
  localparam logic [SYM_W-1:0] C_LAST_SC   = SYM_W'(N_SC - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0] r_acc;        // bit accumulator, or the held word while pend
  logic [CNT_W-1:0] r_bit_cnt;    // bits currently in the accumulator
  logic [SYM_W-1:0] r_sym_cnt;    // subcarrier index within the OFDM symbol
  logic [1:0]       r_mode;       // mode latched on subcarrier 0
  logic             r_pend;       // completed word waiting for the output
  logic             r_pend_last;  // tlast belonging to the held word
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_frame_err;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_re;
  logic [DATA_W-1:0] w_im;
  logic [1:0]        w_mode_eff;
  logic [3:0]        w_bits;
  logic [2:0]        w_bps;
  logic              w_accept;
  logic              w_at_last;
  logic              w_sym_end;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [OUT_W-1:0]  w_next_acc;
  logic [OUT_W-1:0]  w_word;
  logic              w_word_done;
  logic              w_drain;
  logic              w_out_free;

  assign w_re = s_axis_tdata[DATA_W-1:0];
  assign w_im = s_axis_tdata[24+DATA_W-1:24];

  // Padding bits between and above the two components carry no information.
  generate
    if (DATA_W < 24) begin : g_unused_pad
      logic w_unused_pad;
      assign w_unused_pad = ^{s_axis_tdata[47:24+DATA_W], s_axis_tdata[23:DATA_W]};
    end
  endgenerate

  // The first beat of a symbol uses the live mode input; later beats use the
  // copy captured on that first beat so mid-symbol changes are ignored.
  assign w_mode_eff = (r_sym_cnt == '0) ? mode : r_mode;

  mqam_slicer #(
    .DATA_W (DATA_W)
  ) u_slicer (
    .re    (w_re),
    .im    (w_im),
    .thr16 (thr16),
    .mode  (w_mode_eff),
    .bits  (w_bits),
    .bps   (w_bps)
  );

  assign s_axis_tready = en && !r_pend;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_at_last     = (r_sym_cnt == C_LAST_SC);
  assign w_sym_end     = w_at_last || s_axis_tlast;

  // Within a symbol bps is fixed and divides OUT_W, so the count lands exactly
  // on OUT_W and never overshoots.
  assign w_next_cnt  = r_bit_cnt + CNT_W'(w_bps);
  assign w_next_acc  = (r_acc << w_bps) | OUT_W'(w_bits);
  assign w_word_done = w_accept && ((w_next_cnt == C_WORD_BITS) || w_sym_end);

  // Left-justify so the oldest bit sits at the MSB; a short final word is
  // padded with zeros at the LSB end.
  assign w_word = w_next_acc << (C_WORD_BITS - w_next_cnt);

  assign w_drain    = r_out_valid && m_axis_tready;
  assign w_out_free = !r_out_valid || m_axis_tready;

  // Accumulate sliced bits, track position in the symbol, and hold a finished
  // word in the accumulator when the output register cannot take it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_acc       <= '0;
      r_bit_cnt   <= '0;
      r_sym_cnt   <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else if (r_pend) begin
      if (w_drain) begin
        r_pend      <= 1'b0;
        r_pend_last <= 1'b0;
        r_acc       <= '0;
      end
    end else if (w_accept) begin
      if (w_word_done) begin
        r_bit_cnt <= '0;
        if (w_out_free) begin
          r_acc <= '0;
        end else begin
          r_acc       <= w_word;
          r_pend      <= 1'b1;
          r_pend_last <= w_sym_end;
        end
      end else begin
        r_acc     <= w_next_acc;
        r_bit_cnt <= w_next_cnt;
      end
      r_sym_cnt <= w_sym_end ? '0 : r_sym_cnt + 1'b1;
    end
  end

  // Capture the mode on the first accepted beat of each symbol.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_mode <= MODE_BPSK;
    end else if (w_accept && (r_sym_cnt == '0)) begin
      r_mode <= mode;
    end
  end

  // Output register: the held word has priority, then a freshly completed
  // word, otherwise release valid once the consumer takes the current word.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (r_pend && w_drain) begin
      r_out_data  <= r_acc;
      r_out_last  <= r_pend_last;
      r_out_valid <= 1'b1;
    end else if (w_word_done && w_out_free) begin
      r_out_data  <= w_word;
      r_out_last  <= w_sym_end;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // Flag a beat whose tlast disagrees with the nominal symbol length.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept && (s_axis_tlast != w_at_last);
    end
  end

  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_mqam_demod.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_axis_mqam_demod
//  Description : Self-checking bench for axis_mqam_demod. A bit-queue model
//                of the demodulator produces the expected word stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_mqam_demod;

  localparam int DATA_W  = 23;
  localparam int N_SC    = 64;
  localparam int OUT_W   = 32;
  localparam int ABS_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int NEG_MIN = -(1 << (DATA_W - 1));

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [47:0]       s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              en = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic [DATA_W-1:0] thr16 = DATA_W'(32'h100);
  logic              frame_err;

  always #5 aclk = ~aclk;

  axis_mqam_demod #(
    .DATA_W (DATA_W),
    .N_SC   (N_SC),
    .OUT_W  (OUT_W)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .en            (en),
    .mode          (mode),
    .thr16         (thr16),
    .frame_err     (frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Observed traffic, collected at each clock edge.
  logic [OUT_W:0] obs_q[$];
  int             ferr_seen = 0;
  bit             hs_in = 1'b0;

  // Reference model state.
  logic [OUT_W:0] exp_q[$];
  int             exp_ferr = 0;
  int             m_sc = 0;
  int             m_mode = 0;
  bit             m_bits[$];
  int             thr_i = 'h100;

  // Record input/output handshakes and frame_err pulses.
  always @(posedge aclk) begin
    hs_in = s_axis_tvalid && s_axis_tready && !areset;
    if (m_axis_tvalid && m_axis_tready && !areset) obs_q.push_back({m_axis_tlast, m_axis_tdata});
    if (frame_err) ferr_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] pack(input int re, input int im);
    logic [47:0] d;
    d = '0;
    d[DATA_W-1:0]       = re[DATA_W-1:0];
    d[24+DATA_W-1:24]   = im[DATA_W-1:0];
    return d;
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(0, (1 << DATA_W) - 1)) + NEG_MIN;
  endfunction

  function automatic void model_reset();
    m_sc = 0;
    m_bits.delete();
  endfunction

  // One accepted subcarrier: append its decision bits to the symbol's bit
  // stream and cut words of OUT_W bits; the symbol's tail is zero-padded.
  function automatic void model_beat(input int re, input int im, input bit last, input int md, input int thr);
    int ar, ai;
    bit endsym;
    logic [OUT_W-1:0] w;
    if (m_sc == 0) m_mode = md;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    if (ar > ABS_MAX) ar = ABS_MAX;
    if (ai > ABS_MAX) ai = ABS_MAX;
    case (m_mode)
      1: begin
        m_bits.push_back(re >= 0);
        m_bits.push_back(im >= 0);
      end
      2: begin
        m_bits.push_back(re >= 0);
        m_bits.push_back(ar < thr);
        m_bits.push_back(im >= 0);
        m_bits.push_back(ai < thr);
      end
      default: m_bits.push_back(re >= 0);
    endcase
    endsym = last || (m_sc == N_SC - 1);
    if (last != (m_sc == N_SC - 1)) exp_ferr++;
    if (m_bits.size() == OUT_W || endsym) begin
      w = '0;
      for (int k = 0; k < m_bits.size(); k++) w[OUT_W-1-k] = m_bits[k];
      exp_q.push_back({endsym, w});
      m_bits.delete();
    end
    m_sc = endsym ? 0 : m_sc + 1;
  endfunction

  task automatic send_beat(input int re, input int im, input bit last, input int md);
    int waited = 0;
    s_axis_tdata  = pack(re, im);
    s_axis_tlast  = last;
    mode          = md[1:0];
    s_axis_tvalid = 1'b1;
    do begin
      @(posedge aclk); #1;
      waited++;
    end while (!hs_in && waited < 1000);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (hs_in) begin
      model_beat(re, im, last, md, thr_i);
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: got no handshake want handshake within 1000 cycles");
    end
  endtask

  task automatic drain(input int n);
    m_axis_tready = 1'b1;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_bpsk();
    int o0 = obs_q.size(); int e0 = exp_q.size(); int f0 = ferr_seen;
    for (int i = 0; i < N_SC; i++) send_beat((i % 2 == 0) ? 1000 : -1000, 0, i == N_SC - 1, 0);
    drain(10);
    checks++; if (obs_q.size() - o0 !== 2) begin errors++; $display("FAIL bpsk_count: got %0d want 2", obs_q.size() - o0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL bpsk_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
    checks++; if (obs_q[o0] !== {1'b0, 32'hAAAAAAAA}) begin errors++; $display("FAIL bpsk_first: got %h want 0aaaaaaaa", obs_q[o0]); end
    checks++; if (obs_q[o0+1] !== {1'b1, 32'hAAAAAAAA}) begin errors++; $display("FAIL bpsk_second: got %h want 1aaaaaaaa", obs_q[o0+1]); end
    checks++; if (ferr_seen - f0 !== 0) begin errors++; $display("FAIL bpsk_frame_err: got %0d want 0", ferr_seen - f0); end
  endtask

  task automatic test_qpsk();
    int o0 = obs_q.size(); int e0 = exp_q.size();
    for (int i = 0; i < N_SC; i++) send_beat(500, -500, i == N_SC - 1, 1);
    drain(10);
    checks++; if (obs_q.size() - o0 !== 4) begin errors++; $display("FAIL qpsk_count: got %0d want 4", obs_q.size() - o0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL qpsk_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
    checks++; if (obs_q[o0+3] !== {1'b1, 32'hAAAAAAAA}) begin errors++; $display("FAIL qpsk_last: got %h want 1aaaaaaaa", obs_q[o0+3]); end
  endtask

  task automatic test_qam16();
    int o0 = obs_q.size(); int e0 = exp_q.size();
    for (int i = 0; i < N_SC; i++) send_beat('h080, -'h200, i == N_SC - 1, 2);
    // Most-negative input: its clamped magnitude sits just below this threshold.
    thr_i = 1 << (DATA_W - 1);
    thr16 = DATA_W'(thr_i);
    for (int i = 0; i < N_SC; i++) send_beat(NEG_MIN, -ABS_MAX, i == N_SC - 1, 2);
    drain(10);
    thr_i = 'h100;
    thr16 = DATA_W'(thr_i);
    checks++; if (obs_q.size() - o0 !== 16) begin errors++; $display("FAIL qam_count: got %0d want 16", obs_q.size() - o0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL qam_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
    checks++; if (obs_q[o0] !== {1'b0, 32'hCCCCCCCC}) begin errors++; $display("FAIL qam_pattern: got %h want 0cccccccc", obs_q[o0]); end
    checks++; if (obs_q[o0+8] !== {1'b0, 32'h55555555}) begin errors++; $display("FAIL qam_saturate: got %h want 055555555", obs_q[o0+8]); end
  endtask

  task automatic test_early_tlast();
    int o0 = obs_q.size(); int e0 = exp_q.size(); int f0 = ferr_seen;
    for (int i = 0; i < 10; i++) send_beat(100, 0, i == 9, 0);
    for (int i = 0; i < N_SC; i++) send_beat(rnd_val(), rnd_val(), i == N_SC - 1, 1);
    drain(10);
    checks++; if (obs_q[o0] !== {1'b1, 32'hFFC00000}) begin errors++; $display("FAIL early_word: got %h want 1ffc00000", obs_q[o0]); end
    checks++; if (obs_q.size() - o0 !== 5) begin errors++; $display("FAIL early_count: got %0d want 5", obs_q.size() - o0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL early_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
    checks++; if (ferr_seen - f0 !== 1) begin errors++; $display("FAIL early_frame_err: got %0d want 1", ferr_seen - f0); end
  endtask

  task automatic test_backpressure();
    int o0 = obs_q.size(); int e0 = exp_q.size();
    m_axis_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < N_SC; i++) send_beat(rnd_val(), rnd_val(), i == N_SC - 1, 1);
      end
      begin
        int acc_cnt = 0;
        bit seen = 1'b0;
        bit unstable = 1'b0;
        logic [OUT_W:0] held = '0;
        for (int c = 0; c < 40; c++) begin
          @(posedge aclk); #1;
          if (hs_in) acc_cnt++;
          if (m_axis_tvalid) begin
            if (!seen) begin held = {m_axis_tlast, m_axis_tdata}; seen = 1'b1; end
            else if ({m_axis_tlast, m_axis_tdata} !== held) unstable = 1'b1;
          end else if (seen) begin
            unstable = 1'b1;
          end
        end
        checks++; if (acc_cnt !== 32) begin errors++; $display("FAIL bp_accepted: got %0d want 32", acc_cnt); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready: got %b want 0", s_axis_tready); end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_tvalid: got %b want 1", seen); end
        checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL bp_stable: got %b want 0", unstable); end
        m_axis_tready = 1'b1;
      end
    join
    drain(10);
    checks++; if (obs_q.size() - o0 !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", obs_q.size() - o0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL bp_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int o0, e0, f0, x0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) send_beat(rnd_val(), rnd_val(), 1'b0, 1);
    #2;
    areset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_mid_tdata: got %h want 0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_mid_tlast: got %b want 0", m_axis_tlast); end
    @(posedge aclk); #1;
    areset = 1'b0;
    m_axis_tready = 1'b1;
    model_reset();
    o0 = obs_q.size(); e0 = exp_q.size(); f0 = ferr_seen; x0 = exp_ferr;
    for (int i = 0; i < N_SC; i++) send_beat(rnd_val(), rnd_val(), i == N_SC - 1, 0);
    drain(10);
    checks++; if (obs_q.size() - o0 !== 2) begin errors++; $display("FAIL rst_mid_count: got %0d want 2", obs_q.size() - o0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL rst_mid_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
    checks++; if (ferr_seen - f0 !== exp_ferr - x0) begin errors++; $display("FAIL rst_mid_frame_err: got %0d want %0d", ferr_seen - f0, exp_ferr - x0); end
  endtask

  task automatic test_mode_change();
    int o0 = obs_q.size(); int e0 = exp_q.size();
    for (int i = 0; i < N_SC; i++) send_beat(rnd_val(), rnd_val(), i == N_SC - 1, (i < 10) ? 1 : 2);
    for (int i = 0; i < N_SC; i++) send_beat(rnd_val(), rnd_val(), i == N_SC - 1, 2);
    drain(10);
    checks++; if (obs_q.size() - o0 !== 12) begin errors++; $display("FAIL mode_count: got %0d want 12", obs_q.size() - o0); end
    checks++; if (obs_q[o0+3][OUT_W] !== 1'b1) begin errors++; $display("FAIL mode_tlast: got %b want 1", obs_q[o0+3][OUT_W]); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL mode_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
  endtask

  task automatic test_en();
    int o0 = obs_q.size(); int e0 = exp_q.size();
    int re, im;
    bit bad = 1'b0;
    for (int i = 0; i < 20; i++) send_beat(rnd_val(), rnd_val(), 1'b0, 1);
    re = rnd_val(); im = rnd_val();
    en = 1'b0;
    s_axis_tdata  = pack(re, im);
    s_axis_tvalid = 1'b1;
    mode          = 2'd2;
    repeat (5) begin
      @(posedge aclk); #1;
      if (s_axis_tready !== 1'b0 || hs_in) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL en_gate: got accepted want blocked"); end
    en = 1'b1;
    send_beat(re, im, 1'b0, 1);
    for (int i = 21; i < N_SC; i++) send_beat(rnd_val(), rnd_val(), i == N_SC - 1, 1);
    drain(10);
    checks++; if (obs_q.size() - o0 !== 4) begin errors++; $display("FAIL en_count: got %0d want 4", obs_q.size() - o0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL en_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
  endtask

  task automatic test_random();
    int o0 = obs_q.size(); int e0 = exp_q.size(); int f0 = ferr_seen; int x0 = exp_ferr;
    bit done = 1'b0;
    thr_i = int'($urandom_range(0, ABS_MAX));
    thr16 = DATA_W'(thr_i);
    fork
      begin
        for (int i = 0; i < 300; i++)
          send_beat(rnd_val(), rnd_val(), $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)));
        send_beat(rnd_val(), rnd_val(), 1'b1, int'($urandom_range(0, 3)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge aclk);
          m_axis_tready = ($urandom_range(0, 3) != 0);
          en            = ($urandom_range(0, 4) != 0);
        end
      end
    join
    en = 1'b1;
    drain(40);
    checks++; if (obs_q.size() - o0 !== exp_q.size() - e0) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size() - o0, exp_q.size() - e0); end
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      checks++;
      if (o0 + i >= obs_q.size() || obs_q[o0+i] !== exp_q[e0+i]) begin
        errors++; $display("FAIL rand_word%0d: got %h want %h", i, (o0 + i < obs_q.size()) ? obs_q[o0+i] : 'x, exp_q[e0+i]);
      end
    end
    checks++; if (ferr_seen - f0 !== exp_ferr - x0) begin errors++; $display("FAIL rand_frame_err: got %0d want %0d", ferr_seen - f0, exp_ferr - x0); end
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qpsk();
    test_qam16();
    test_early_tlast();
    test_backpressure();
    test_reset_mid();
    test_mode_change();
    test_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
